i2c_target_regfile: RTL and testbench

- Parametrised successor to the team's single-byte I2C slave: an I2C target that fronts an external register bank.
- Supports multi-byte burst write and read, an auto-incrementing register pointer, repeated START, and master NACK termination.
- Filters SCL/SDA internally and drives SDA open-drain.
- Sits between the board I2C pins and a peripheral's control/status registers.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 44 ++++
 rtl/i2c_target_regfile.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned ACK_BIT   = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample glitch filter and registered edge pulses
// for one raw I2C pin.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target fronting an external register bank: burst write/read with an
// auto-incrementing pointer, repeated START and master NACK termination.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 8,
  parameter int unsigned NUM_REGS   = 256,
  parameter int unsigned FILTER_LEN = 3,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            dev_addr,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [7:0]            reg_wr_data,
  output logic                  reg_rd_en,
  input  logic [7:0]            reg_rd_data,
  output logic                  busy,
  output logic                  addressed
);

  localparam int unsigned PW = REG_ADDR_W;

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t               state, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [7:0]           shift, shift_d;
  logic [7:0]           tx, tx_d;
  logic                 rd_lat, rd_lat_d;
  logic                 adv_pend, adv_pend_d;
  logic                 sda_oe_d;
  logic [PW-1:0]        reg_addr_d;
  logic                 reg_wr_en_d;
  logic [7:0]           reg_wr_data_d;
  logic                 reg_rd_en_d;
  logic                 busy_d;
  logic                 addressed_d;

  logic                 start_c, stop_c, last_bit_c;
  logic [7:0]           shift_in_c;
  logic [PW-1:0]        ptr_adv_c;

  assign start_c    = sda_fall & scl;
  assign stop_c     = sda_rise & scl;
  assign last_bit_c = (bit_cnt == BIT_CNT_W'(BYTE_BITS - 1));
  assign shift_in_c = {shift[6:0], sda};
  assign ptr_adv_c  = !AUTO_INC ? reg_addr :
                      (reg_addr == PW'(NUM_REGS - 1)) ? '0 : reg_addr + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= '0;
      rd_lat      <= 1'b0;
      adv_pend    <= 1'b0;
      sda_oe      <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      addressed   <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shift       <= shift_d;
      tx          <= tx_d;
      rd_lat      <= rd_lat_d;
      adv_pend    <= adv_pend_d;
      sda_oe      <= sda_oe_d;
      reg_addr    <= reg_addr_d;
      reg_wr_en   <= reg_wr_en_d;
      reg_wr_data <= reg_wr_data_d;
      reg_rd_en   <= reg_rd_en_d;
      busy        <= busy_d;
      addressed   <= addressed_d;
    end
  end

  // ACK phases hand over to the next state on the ACK rise; the following
  // SCL fall then releases SDA or drives the first read bit.
  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    shift_d       = shift;
    tx_d          = tx;
    rd_lat_d      = reg_rd_en;
    adv_pend_d    = 1'b0;
    sda_oe_d      = sda_oe;
    reg_addr_d    = reg_addr;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data;
    reg_rd_en_d   = 1'b0;
    busy_d        = busy;
    addressed_d   = addressed;

    if (adv_pend) reg_addr_d = ptr_adv_c;
    if (rd_lat)   tx_d       = reg_rd_data;

    if (stop_c) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (start_c) begin
      state_d     = ADDR;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE, WAIT_STOP: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in_c;
            if (!last_bit_c) begin
              bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
            end else if (shift_in_c[7:1] == dev_addr) begin
              state_d     = ADDR_ACK;
              addressed_d = 1'b1;
              bit_cnt_d   = BIT_CNT_W'(ACK_BIT);
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b1;
          if (scl_rise) begin
            bit_cnt_d = '0;
            if (shift[0]) begin
              state_d     = RDATA;
              reg_rd_en_d = 1'b1;
            end else begin
              state_d = PTR;
            end
          end
        end
        PTR, WDATA: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d = shift_in_c;
            if (!last_bit_c) begin
              bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
            end else begin
              bit_cnt_d = BIT_CNT_W'(ACK_BIT);
              if (state == PTR) begin
                state_d    = PTR_ACK;
                reg_addr_d = shift_in_c[PW-1:0];
              end else begin
                state_d = WDATA_ACK;
              end
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) sda_oe_d = 1'b1;
          if (scl_rise) begin
            state_d   = WDATA;
            bit_cnt_d = '0;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d      = 1'b1;
            reg_wr_en_d   = 1'b1;
            reg_wr_data_d = shift;
            adv_pend_d    = 1'b1;
          end
          if (scl_rise) begin
            state_d   = WDATA;
            bit_cnt_d = '0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            sda_oe_d = ~tx[7];
            tx_d     = {tx[6:0], 1'b0};
          end
          if (scl_rise) begin
            if (last_bit_c) begin
              state_d   = RACK;
              bit_cnt_d = BIT_CNT_W'(ACK_BIT);
            end else begin
              bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        RACK: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (!sda) begin
              state_d     = RDATA;
              reg_addr_d  = ptr_adv_c;
              reg_rd_en_d = 1'b1;
              bit_cnt_d   = '0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C master driving two targets (auto-increment and held pointer)
// on one open-drain bus, checked against an array model of banks and pointers.
module tb_i2c_target_regfile;

  localparam int unsigned QCYC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;

  logic       oe_a, we_a, re_a, busy_a, adr_a;
  logic [7:0] addr_a, wd_a;
  logic [7:0] rd_a;
  logic       oe_b, we_b, re_b, busy_b, adr_b;
  logic [7:0] addr_b, wd_b;
  logic [7:0] rd_b;

  assign sda_line = sda_m & ~oe_a & ~oe_b;

  i2c_target_regfile #(.REG_ADDR_W(8), .NUM_REGS(256), .FILTER_LEN(3), .AUTO_INC(1'b1)) u_dut (
    .clk(clk), .rst(rst), .dev_addr(7'h50), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(oe_a), .reg_addr(addr_a), .reg_wr_en(we_a), .reg_wr_data(wd_a),
    .reg_rd_en(re_a), .reg_rd_data(rd_a), .busy(busy_a), .addressed(adr_a)
  );

  i2c_target_regfile #(.REG_ADDR_W(8), .NUM_REGS(256), .FILTER_LEN(3), .AUTO_INC(1'b0)) u_dut_hold (
    .clk(clk), .rst(rst), .dev_addr(7'h30), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(oe_b), .reg_addr(addr_b), .reg_wr_en(we_b), .reg_wr_data(wd_b),
    .reg_rd_en(re_b), .reg_rd_data(rd_b), .busy(busy_b), .addressed(adr_b)
  );

  // Register banks: A holds its index, B its complement, after reset.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'(i);
        mem_b[i] <= ~8'(i);
      end
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (we_a) mem_a[addr_a] <= wd_a;
      if (re_a) rd_a <= mem_a[addr_a];
      if (we_b) mem_b[addr_b] <= wd_b;
      if (re_b) rd_b <= mem_b[addr_b];
    end
  end

  logic [15:0] wlog_a [1024];
  logic [15:0] wlog_b [1024];
  logic [9:0]  wcnt_a = '0;
  logic [9:0]  wcnt_b = '0;
  int          oe_cnt = 0;
  always @(posedge clk) begin
    if (we_a) begin wlog_a[wcnt_a] <= {addr_a, wd_a}; wcnt_a <= wcnt_a + 10'd1; end
    if (we_b) begin wlog_b[wcnt_b] <= {addr_b, wd_b}; wcnt_b <= wcnt_b + 10'd1; end
    if (oe_a | oe_b) oe_cnt <= oe_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  logic [7:0] mem_m [2][256];
  int         ptr_m [2];
  bit         inc_m [2] = '{1'b1, 1'b0};
  logic [6:0] dadr  [2] = '{7'h50, 7'h30};
  logic [7:0] wbuf  [8];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mem_m[0][i] = 8'(i);
      mem_m[1][i] = ~8'(i);
    end
    ptr_m[0] = 0;
    ptr_m[1] = 0;
  endtask

  function automatic int nxt(input int d, input int p);
    return inc_m[d] ? ((p + 1) % 256) : p;
  endfunction

  // Bus primitives; every bit starts and ends with SCL low.
  task automatic qw();
    repeat (QCYC) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw();
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    sda_m = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      scl_m = 1'b1;
      @(negedge clk);
      scl_m = 1'b0;
      repeat (QCYC - 4) @(negedge clk);
    end else begin
      qw();
    end
    scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); b = sda_line; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] v, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i], i == gbit);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack, 1'b0);
  endtask

  task automatic do_write(input int d, input logic [7:0] p, input int n, input int gbit);
    logic       ack;
    logic [9:0] base;
    logic [7:0] ea [8];
    logic [7:0] ed [8];
    logic [15:0] e;
    base = d ? wcnt_b : wcnt_a;
    i2c_start();
    write_byte({dadr[d], 1'b0}, -1, ack);
    check("w_addr_ack", 32'(ack), 32'd0);
    write_byte(p, -1, ack);
    check("w_ptr_ack", 32'(ack), 32'd0);
    ptr_m[d] = int'(p);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], (i == 0) ? gbit : -1, ack);
      check("w_data_ack", 32'(ack), 32'd0);
      ea[i] = 8'(ptr_m[d]);
      ed[i] = wbuf[i];
      mem_m[d][ptr_m[d]] = wbuf[i];
      ptr_m[d] = nxt(d, ptr_m[d]);
    end
    i2c_stop();
    repeat (4) @(negedge clk);
    check("wr_count", 32'(10'((d ? wcnt_b : wcnt_a) - base)), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = d ? wlog_b[10'(base + 10'(i))] : wlog_a[10'(base + 10'(i))];
      check("wr_addr", 32'(e[15:8]), 32'(ea[i]));
      check("wr_data", 32'(e[7:0]), 32'(ed[i]));
    end
    check("ptr_after_wr", 32'(d ? addr_b : addr_a), 32'(ptr_m[d]));
    check("busy_after_stop", 32'(d ? busy_b : busy_a), 32'd0);
  endtask

  task automatic do_read(input int d, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] v;
    i2c_start();
    write_byte({dadr[d], 1'b0}, -1, ack);
    check("r_waddr_ack", 32'(ack), 32'd0);
    write_byte(p, -1, ack);
    check("r_ptr_ack", 32'(ack), 32'd0);
    ptr_m[d] = int'(p);
    i2c_start();
    write_byte({dadr[d], 1'b1}, -1, ack);
    check("r_raddr_ack", 32'(ack), 32'd0);
    check("r_addressed", 32'(d ? adr_b : adr_a), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(v, i == n - 1);
      check("rd_byte", 32'(v), 32'(mem_m[d][ptr_m[d]]));
      if (i < n - 1) ptr_m[d] = nxt(d, ptr_m[d]);
    end
    check("oe_after_nack", 32'(d ? oe_b : oe_a), 32'd0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("ptr_after_rd", 32'(d ? addr_b : addr_a), 32'(ptr_m[d]));
  endtask

  initial begin
    logic       ack;
    int         oe0, p_rst;
    logic [9:0] wa0, wb0;

    model_reset();
    repeat (5) @(negedge clk);
    check("rst_oe", 32'(oe_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_addressed", 32'(adr_a), 32'd0);
    check("rst_reg_addr", 32'(addr_a), 32'd0);
    check("rst_wr_en", 32'(we_a), 32'd0);
    check("rst_wr_data", 32'(wd_a), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Burst write at 0x10.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(0, 8'h10, 3, -1);

    // Address nobody answers to.
    oe0 = oe_cnt; wa0 = wcnt_a; wb0 = wcnt_b;
    i2c_start();
    check("nm_busy", 32'(busy_a), 32'd1);
    write_byte(8'hA2, -1, ack);
    check("nm_nack", 32'(ack), 32'd1);
    check("nm_addressed", 32'({adr_a, adr_b}), 32'd0);
    write_byte(8'h5A, -1, ack);
    check("nm_busy_mid", 32'(busy_a), 32'd1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("nm_oe_never", 32'(oe_cnt - oe0), 32'd0);
    check("nm_no_strobe", 32'({wcnt_a - wa0, wcnt_b - wb0}), 32'd0);

    // Read across the pointer wrap.
    do_read(0, 8'hFE, 3);

    // Held pointer target.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(1, 8'h05, 2, -1);

    // SCL glitch inside the first data byte.
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(0, 8'($urandom), 2, 3);

    // Randomised mix of writes, pointer-only writes and reads.
    for (int it = 0; it < 12; it++) begin
      int         d, n;
      logic [7:0] p;
      d = int'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + 8'($urandom_range(0, 3))) : 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        n = int'($urandom_range(0, 4));
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(d, p, n, -1);
      end else begin
        do_read(d, p, int'($urandom_range(1, 4)));
      end
    end

    // Reset while the target drives a 0 data bit.
    p_rst = 0;
    for (int i = 255; i >= 0; i--) if (mem_m[0][i][7] == 1'b0) p_rst = i;
    i2c_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'(p_rst), -1, ack);
    i2c_start();
    write_byte(8'hA1, -1, ack);
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw();
    check("mr_driving", 32'(oe_a), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mr_oe_released", 32'(oe_a), 32'd0);
    check("mr_busy", 32'(busy_a), 32'd0);
    check("mr_reg_addr", 32'(addr_a), 32'd0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    scl_m = 1'b0; qw();
    i2c_stop();
    repeat (10) @(negedge clk);
    check("mr_idle_busy", 32'(busy_a), 32'd0);

    // Clean transfers after the reset.
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write(0, 8'($urandom), 2, -1);
    do_read(1, 8'($urandom), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
